// File: rtl/track_buffer_sd_loader_if.sv
// SD controller byte-stream handshake and track buffer port B, bundled.
// master: the loader sequencer; slave: SD controller / RAM side.
interface track_buffer_sd_loader_if;
    logic        sd_rd;
    logic        sd_wr;
    logic [31:0] sd_lba;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic [8:0]  buf_ad;
    logic [7:0]  buf_din;
    logic        buf_we;
    logic        buf_ce;
    logic [7:0]  buf_dout;

    modport master (
        output sd_rd, sd_wr, sd_lba, sd_buff_din, buf_ad, buf_din, buf_we, buf_ce,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, buf_dout
    );

    modport slave (
        input  sd_rd, sd_wr, sd_lba, sd_buff_din, buf_ad, buf_din, buf_we, buf_ce,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, buf_dout
    );
endinterface

// File: rtl/track_buffer_sd_loader.sv
// Track buffer <-> SD card sequencer: loads a 512-byte sector into port B of
// the track buffer RAM, writes it back on request, and flushes a dirty buffer
// before loading a new sector over it.
// Optional: define TRACK_BUFFER_SD_TIMEOUT_EN to add a per-request watchdog.
module track_buffer_sd_loader #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd16000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_req,
    input  logic        save_req,
    input  logic [31:0] lba,
    input  logic        drive_dirty,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        valid,
    output logic [31:0] cur_lba,
    track_buffer_sd_loader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, FLUSH_REQ, FLUSH_XFER, LOAD_REQ, LOAD_XFER, SAVE_REQ, SAVE_XFER
    } state_t;

    state_t      state, state_n;
    logic        dirty;
    logic [31:0] pend_lba;
    logic [9:0]  byte_cnt;
    logic        we_q;
    logic [8:0]  ad_q;
    logic [7:0]  din_q;
    logic        wr_xfer;
    logic        tmo;

`ifdef TRACK_BUFFER_SD_TIMEOUT_EN
    logic [23:0] wd_cnt;

    // Watchdog restarts on each new SD request and runs until back in IDLE
    always_ff @(posedge clk) begin
        if (reset || state == IDLE ||
            (state_n != state && (state_n == FLUSH_REQ || state_n == LOAD_REQ || state_n == SAVE_REQ)))
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 24'd1;
    end

    assign tmo = (state != IDLE) && (wd_cnt == TIMEOUT_CYCLES - 24'd1);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic; load wins over save, requests only taken in IDLE
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (load_req)
                    state_n = (valid && dirty) ? FLUSH_REQ : LOAD_REQ;
                else if (save_req && valid)
                    state_n = SAVE_REQ;
            end
            FLUSH_REQ:  if (bus.sd_ack)  state_n = FLUSH_XFER;
            FLUSH_XFER: if (!bus.sd_ack) state_n = LOAD_REQ;
            LOAD_REQ:   if (bus.sd_ack)  state_n = LOAD_XFER;
            LOAD_XFER:  if (!bus.sd_ack) state_n = IDLE;
            SAVE_REQ:   if (bus.sd_ack)  state_n = SAVE_XFER;
            SAVE_XFER:  if (!bus.sd_ack) state_n = IDLE;
            default:    state_n = IDLE;
        endcase
        if (tmo) state_n = IDLE;
    end

    // SD request, address muxing and port B drive
    always_comb begin
        wr_xfer          = (state == FLUSH_XFER) || (state == SAVE_XFER);
        busy             = (state != IDLE);
        // keep the RAM enabled for a registered write that lands after exit
        bus.buf_ce       = busy || we_q;
        bus.sd_rd        = (state == LOAD_REQ);
        bus.sd_wr        = (state == FLUSH_REQ) || (state == SAVE_REQ);
        bus.buf_ad       = wr_xfer ? bus.sd_buff_addr : ad_q;
        bus.sd_buff_din  = wr_xfer ? bus.buf_dout : '0;
        bus.buf_din      = din_q;
        bus.buf_we       = we_q;
        case (state)
            LOAD_REQ, LOAD_XFER:                        bus.sd_lba = pend_lba;
            FLUSH_REQ, FLUSH_XFER, SAVE_REQ, SAVE_XFER: bus.sd_lba = cur_lba;
            default:                                    bus.sd_lba = '0;
        endcase
    end

    // Read path: register each SD strobe into a port B write, count bytes
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q     <= 1'b0;
            ad_q     <= '0;
            din_q    <= '0;
            byte_cnt <= '0;
        end else begin
            we_q <= (state == LOAD_XFER) && bus.sd_buff_wr;
            if (state == LOAD_XFER && bus.sd_buff_wr) begin
                ad_q     <= bus.sd_buff_addr;
                din_q    <= bus.sd_buff_dout;
                byte_cnt <= byte_cnt + 10'd1;
            end else if (state == LOAD_REQ) begin
                byte_cnt <= '0;
            end
        end
    end

    // Status: done/err/valid/cur_lba bookkeeping and the dirty flag
    always_ff @(posedge clk) begin
        if (reset) begin
            done     <= 1'b0;
            err      <= 1'b0;
            valid    <= 1'b0;
            cur_lba  <= '0;
            pend_lba <= '0;
            dirty    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (tmo) begin
                err   <= 1'b1;
                valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (load_req) begin
                            err      <= 1'b0;
                            pend_lba <= lba;
                        end else if (save_req) begin
                            err <= 1'b0;
                            if (!valid) done <= 1'b1;
                        end
                    end
                    LOAD_XFER: begin
                        if (!bus.sd_ack) begin
                            if (byte_cnt == 10'd512) begin
                                valid   <= 1'b1;
                                cur_lba <= pend_lba;
                                done    <= 1'b1;
                            end else begin
                                valid <= 1'b0;
                                err   <= 1'b1;
                            end
                        end
                    end
                    SAVE_XFER: if (!bus.sd_ack) done <= 1'b1;
                    default: ;
                endcase
            end

            // a drive write racing the start of a write-back must survive it
            if (tmo || (state == LOAD_XFER && !bus.sd_ack))
                dirty <= 1'b0;
            else if (drive_dirty && valid)
                dirty <= 1'b1;
            else if (state == IDLE && (state_n == FLUSH_REQ || state_n == SAVE_REQ))
                dirty <= 1'b0;
        end
    end

endmodule

// File: tb/tb_track_buffer_sd_loader.sv
// Bench for track_buffer_sd_loader: models the SD controller and the track
// buffer RAM, and keeps a reference of buffer contents and loader status.
module tb_track_buffer_sd_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_req = 1'b0;
    logic        save_req = 1'b0;
    logic        drive_dirty = 1'b0;
    logic [31:0] lba = '0;
    logic        busy, done, err, valid;
    logic [31:0] cur_lba;

    track_buffer_sd_loader_if bus();

    track_buffer_sd_loader #(.TIMEOUT_CYCLES(24'd100)) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .save_req(save_req),
        .lba(lba), .drive_dirty(drive_dirty), .busy(busy), .done(done),
        .err(err), .valid(valid), .cur_lba(cur_lba), .bus(bus)
    );

    always #5 clk = ~clk;

    // Track buffer RAM: port A for the drive, port B (bypass) for the loader
    logic [7:0] mem [512];
    logic       pa_we = 1'b0;
    logic [8:0] pa_addr = '0;
    logic [7:0] pa_data = '0;

    always @(posedge clk) begin
        if (pa_we) mem[pa_addr] <= pa_data;
        if (bus.buf_ce) begin
            if (bus.buf_we) begin
                mem[bus.buf_ad] <= bus.buf_din;
                bus.buf_dout    <= bus.buf_din;
            end else begin
                bus.buf_dout <= mem[bus.buf_ad];
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Reference model
    logic [7:0]  exp_buf [512];
    logic [7:0]  cap [512];
    bit          m_valid = 0, m_dirty = 0, m_err = 0;
    logic [31:0] m_cur = '0;
    logic [7:0]  salt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic buf_compare(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== exp_buf[i]) mism++;
        chk({tag, "_buf"}, mism, 0);
    endtask

    // Plays the SD controller for one request
    task automatic serve(input bit exp_wr, input logic [31:0] exp_lba, input int n,
                         input bit mid_dirty, input bit mid_load, input string tag);
        int w;
        int mism;
        w = 0;
        while (bus.sd_rd !== 1'b1 && bus.sd_wr !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_req_seen"}, (w < 50), 1);
        if (w >= 50) return;
        chk({tag, "_op"}, {bus.sd_wr, bus.sd_rd}, exp_wr ? 2'b10 : 2'b01);
        chk({tag, "_lba"}, bus.sd_lba, exp_lba);
        bus.sd_ack = 1'b1;
        @(negedge clk);
        chk({tag, "_drop"}, {bus.sd_wr, bus.sd_rd}, 0);
        if (!exp_wr) begin
            for (int i = 0; i < n; i++) begin
                bus.sd_buff_addr = 9'(i);
                bus.sd_buff_dout = 8'(i) ^ salt;
                bus.sd_buff_wr   = 1'b1;
                drive_dirty = mid_dirty && (i == 100);
                load_req    = mid_load && (i == 100);
                @(negedge clk);
                if (i == 0) chk({tag, "_we_lat"}, {bus.buf_we, bus.buf_ad}, {1'b1, 9'd0});
                exp_buf[i] = 8'(i) ^ salt;
            end
            bus.sd_buff_wr = 1'b0;
            drive_dirty = 1'b0;
            load_req = 1'b0;
            @(negedge clk);
        end else begin
            for (int i = 0; i <= 512; i++) begin
                if (i > 0) cap[i-1] = bus.sd_buff_din;
                if (i < 512) bus.sd_buff_addr = 9'(i);
                drive_dirty = mid_dirty && (i == 100);
                load_req    = mid_load && (i == 100);
                @(negedge clk);
            end
            drive_dirty = 1'b0;
            load_req = 1'b0;
            mism = 0;
            for (int i = 0; i < 512; i++) if (cap[i] !== exp_buf[i]) mism++;
            chk({tag, "_wdata"}, mism, 0);
        end
        bus.sd_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_load(input logic [31:0] l, input int n, input bit also_save,
                           input bit mid_load, input string tag);
        bit fl;
        int d0;
        int extra;
        fl = m_valid && m_dirty;
        d0 = done_cnt;
        @(negedge clk);
        load_req = 1'b1; save_req = also_save; lba = l;
        @(negedge clk);
        load_req = 1'b0; save_req = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_req_next"}, fl ? bus.sd_wr : bus.sd_rd, 1);
        if (fl) begin
            serve(1'b1, m_cur, 512, 1'b0, 1'b0, {tag, "_flush"});
            m_dirty = 0;
        end
        serve(1'b0, l, n, 1'b0, mid_load, tag);
        repeat (2) @(negedge clk);
        if (n == 512) begin
            m_valid = 1; m_cur = l; m_err = 0;
        end else begin
            m_valid = 0; m_err = 1;
        end
        m_dirty = 0;
        chk({tag, "_done"}, done_cnt - d0, (n == 512) ? 1 : 0);
        chk({tag, "_err"}, err, m_err);
        chk({tag, "_valid"}, valid, m_valid);
        chk({tag, "_cur"}, cur_lba, m_cur);
        chk({tag, "_idle"}, busy, 0);
        buf_compare(tag);
        if (mid_load) begin
            extra = 0;
            repeat (10) begin
                @(negedge clk);
                if (bus.sd_rd === 1'b1 || bus.sd_wr === 1'b1 || busy === 1'b1) extra++;
            end
            chk({tag, "_ignored"}, extra, 0);
        end
    endtask

    task automatic do_save(input bit mid_dirty, input string tag);
        int d0;
        bit go;
        d0 = done_cnt;
        go = m_valid;
        @(negedge clk);
        save_req = 1'b1;
        @(negedge clk);
        save_req = 1'b0;
        if (go) begin
            chk({tag, "_req_next"}, bus.sd_wr, 1);
            serve(1'b1, m_cur, 512, mid_dirty, 1'b0, tag);
            m_dirty = mid_dirty;
        end else begin
            chk({tag, "_nobusy"}, busy, 0);
            chk({tag, "_nowr"}, bus.sd_wr, 0);
        end
        repeat (2) @(negedge clk);
        m_err = 0;
        chk({tag, "_done"}, done_cnt - d0, 1);
        chk({tag, "_err"}, err, m_err);
        chk({tag, "_valid"}, valid, m_valid);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic drive_write(input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        pa_we = 1'b1; pa_addr = a; pa_data = d;
        @(negedge clk);
        pa_we = 1'b0;
        exp_buf[a] = d;
    endtask

    task automatic drive_mark_dirty();
        @(negedge clk);
        drive_dirty = 1'b1;
        @(negedge clk);
        drive_dirty = 1'b0;
        if (m_valid) m_dirty = 1;
    endtask

    task automatic drive_edit();
        int k;
        k = $urandom_range(3, 8);
        for (int i = 0; i < k; i++) drive_write(9'($urandom), 8'($urandom));
        drive_mark_dirty();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int cnt;
        logic [31:0] tl;
        bus.sd_ack = 1'b0;
        bus.sd_buff_addr = '0;
        bus.sd_buff_dout = '0;
        bus.sd_buff_wr = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_outs", {busy, done, err, valid, bus.sd_rd, bus.sd_wr, bus.buf_we, bus.buf_ce}, 0);
        chk("rst_cur", cur_lba, 0);
        chk("rst_sdlba", bus.sd_lba, 0);
        reset = 1'b0;

        salt = 8'h00;
        do_load(32'h1234, 512, 1'b0, 1'b0, "load1");

        salt = 8'($urandom);
        do_load($urandom, 300, 1'b0, 1'b0, "short");

        do_save(1'b0, "save_inv");

        salt = 8'($urandom);
        do_load($urandom, 512, 1'b0, 1'b0, "load2");
        drive_edit();
        salt = 8'($urandom);
        do_load(32'h20, 512, 1'b0, 1'b0, "load_flush");

        drive_edit();
        do_save(1'b0, "save1");

        salt = 8'($urandom);
        do_load($urandom, 512, 1'b1, 1'b1, "load_both");

        drive_edit();
        do_save(1'b1, "save_mid");
        salt = 8'($urandom);
        do_load($urandom, 512, 1'b0, 1'b0, "load_after_save");

        for (int r = 0; r < 3; r++) begin
            if ($urandom_range(0, 1) == 1) drive_edit();
            salt = 8'($urandom);
            do_load($urandom, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 511)) : 512,
                    1'b0, 1'b0, "rand_load");
        end

        // Reset in the middle of a read transfer (buffer left clean above)
        if (m_valid && m_dirty) do_save(1'b0, "pre_rst_save");
        tl = $urandom;
        salt = 8'($urandom);
        @(negedge clk);
        load_req = 1'b1; lba = tl;
        @(negedge clk);
        load_req = 1'b0;
        chk("rst_mid_req", bus.sd_rd, 1);
        bus.sd_ack = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.sd_buff_addr = 9'(i);
            bus.sd_buff_dout = 8'(i) ^ salt;
            bus.sd_buff_wr = 1'b1;
            @(negedge clk);
            exp_buf[i] = 8'(i) ^ salt;
        end
        bus.sd_buff_wr = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.sd_ack = 1'b0;
        @(negedge clk);
        m_valid = 0; m_dirty = 0; m_err = 0; m_cur = '0;
        chk("rst_mid_valid", valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_req_low", {bus.sd_rd, bus.sd_wr}, 0);
        chk("rst_mid_err", err, 0);

`ifdef TRACK_BUFFER_SD_TIMEOUT_EN
        @(negedge clk);
        load_req = 1'b1; lba = $urandom;
        @(negedge clk);
        load_req = 1'b0;
        cnt = 0;
        while (bus.sd_rd === 1'b1 && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        m_valid = 0; m_err = 1;
        chk("tmo_cycles", cnt, 100);
        chk("tmo_err", err, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_valid", valid, 0);
`else
        cnt = 0;
`endif

        salt = 8'($urandom);
        do_load($urandom, 512, 1'b0, 1'b0, "recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/track_buffer_sd_loader.md
# track_buffer_sd_loader

Sequencer that fills the 512-byte floppy track buffer from the SD card and writes modified contents back. It sits between the SD block controller (sd_rd/sd_wr/sd_ack byte-stream handshake) and port B of the track buffer dual-port RAM; the drive emulation uses port A. It tracks which LBA the buffer holds and whether the drive has dirtied it. Before loading a new sector over a dirty one, it flushes the old sector automatically.

## Interface
Parameters:
- TIMEOUT_CYCLES, 24'd16000000, cycles allowed from request assertion to sd_ack fall (used only with the timeout option)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- load_req  in  1  one-cycle pulse: load sector at lba
- save_req  in  1  one-cycle pulse: write current buffer back to cur_lba
- lba  in  32  sector to load, sampled with load_req
- drive_dirty  in  1  pulse: drive wrote buffer via port A
- busy  out  1  high from accepted request until return to IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky error; cleared when the next request is accepted
- valid  out  1  buffer holds cur_lba contents
- cur_lba  out  32  LBA currently held
- sd_rd, sd_wr  out  1  read/write request to SD controller
- sd_lba  out  32  LBA for the request
- sd_ack  in  1  SD controller transfer window
- sd_buff_addr  in  9  byte index from SD controller
- sd_buff_dout  in  8  read data byte
- sd_buff_wr  in  1  read data strobe
- sd_buff_din  out  8  write data to SD controller
- buf_ad  out  9  track buffer port B address
- buf_din  out  8  port B write data
- buf_we  out  1  port B write enable
- buf_ce  out  1  port B clock enable
- buf_dout  in  8  port B read data (synchronous, 1-cycle latency, bypass mode)

## Operation
- States: IDLE, FLUSH_REQ, FLUSH_XFER, LOAD_REQ, LOAD_XFER, SAVE_REQ, SAVE_XFER.
- Requests are accepted only in IDLE. Pulses arriving while busy are dropped. If load_req and save_req arrive together, load wins.
- load_req with valid and dirty high: latch lba as pending, then go to FLUSH_REQ (writes cur_lba), then LOAD_REQ. Otherwise go directly to LOAD_REQ.
- *_REQ states: drive sd_rd (load) or sd_wr (flush/save) high with sd_lba set. Drop the request the cycle sd_ack is first seen high, then move to *_XFER.
- LOAD_XFER: each sd_buff_wr produces, registered one cycle later, buf_we=1, buf_ad=sd_buff_addr, buf_din=sd_buff_dout. A 10-bit byte counter increments per strobe.
- LOAD_XFER exit on sd_ack low:
  - count = 512: valid=1, cur_lba=pending lba, dirty=0, done pulse.
  - otherwise: valid=0, err=1, no done.
- SAVE/FLUSH_XFER: buf_ad = sd_buff_addr (combinational) and sd_buff_din = buf_dout. The SD controller's contract absorbs the 1-cycle RAM latency.
- SAVE/FLUSH_XFER exit on sd_ack low: save produces a done pulse; flush proceeds to LOAD_REQ with no done pulse.
- Dirty flag:
  - drive_dirty sets it only when valid.
  - It is cleared on entering FLUSH_REQ/SAVE_REQ. A drive_dirty in that same cycle or later re-sets it.
- save_req with valid=0 completes immediately: done pulse, no SD access.
- buf_ce is high whenever the state is not IDLE.

## Timing
- Reset values: all outputs 0. State IDLE, dirty=0, counter 0.
- Request accept → sd_rd/sd_wr high on the next cycle.
- sd_ack seen high at edge N → request low after edge N.
- sd_buff_wr at edge N → buf_we high during cycle N+1.
- sd_ack low seen at edge N → done/err/valid updated after edge N; busy low the following cycle.
- Reset mid-transfer: immediate return to IDLE, valid=0, requests dropped.

## Configuration
- TRACK_BUFFER_SD_TIMEOUT_EN defined:
  - A 24-bit watchdog counts in every *_REQ/*_XFER state.
  - At TIMEOUT_CYCLES it drops sd_rd/sd_wr, sets err=1 and valid=0, and returns to IDLE with no done pulse.
- Undefined: no watchdog; the FSM waits on sd_ack indefinitely.

## Test plan
- Load lba=0x1234 with 512 strobes of data = addr[7:0] → buffer matches, done pulse, valid=1, cur_lba=0x1234, err=0.
- Load with only 300 strobes → err=1, valid=0, no done.
- drive_dirty, then load lba=0x20 → sd_wr with sd_lba=old LBA precedes sd_rd with sd_lba=0x20; single done at end.
- save_req with valid=1 → sd_wr, sd_buff_din equals RAM contents for every sd_buff_addr, done pulse, dirty cleared; drive_dirty during SAVE_XFER leaves dirty=1.
- load_req while busy, and load_req+save_req in the same cycle → the busy request is ignored; in the simultaneous case, load executes.
- With TRACK_BUFFER_SD_TIMEOUT_EN and TIMEOUT_CYCLES=100, sd_ack never asserted → sd_rd drops at cycle 100, err=1, busy=0.
